// File: rtl/input_cond_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : input_cond_pkg
//  Description : Shared constants for the input conditioning stage. These are
//                the channel indices and the default debounce depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package input_cond_pkg;

  // Channel ordering on raw_in / level_out / pulse_out
  localparam int CH_C1 = 0;
  localparam int CH_C2 = 1;
  localparam int CH_I  = 2;

  // Consecutive stable samples needed to accept a new level
  localparam int DEBOUNCE_DEFAULT = 4;

endpackage : input_cond_pkg
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_channel
//  Description : One input line. It passes through a 2-flop synchroniser,
//                then a stability counter that accepts a new level after
//                DEBOUNCE_CYCLES consecutive mismatching samples. It also
//                drives a registered one-cycle pulse on every accepted rise.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_pulse,
  output logic o_busy
);

  // Last count value before a persistent mismatch is committed as the new level
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_level;
  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;

  logic             w_mismatch;
  logic             w_commit;

  assign w_mismatch = (r_s2 != r_level);
  // With DEBOUNCE_CYCLES = 1 the last count is 0, so the first mismatch commits
  assign w_commit   = w_mismatch && (r_cnt == c_cnt_last);

  // Bring the asynchronous pad line into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
    end
  end

  // Count consecutive mismatches. Any matching sample restarts the count,
  // and the counter never passes c_cnt_last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (!w_mismatch) begin
      r_cnt   <= '0;
    end else if (w_commit) begin
      r_cnt   <= '0;
      r_level <= r_s2;
    end else begin
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  // Fire for the one cycle in which the level has just become 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= w_commit & r_s2;
    end
  end

  assign o_level = r_level;
  assign o_pulse = r_pulse;
  assign o_busy  = (r_cnt != '0);

endmodule : debounce_channel
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : input_conditioner
//  Description : Synchronises and debounces the C1/C2/I pad lines. It presents
//                clean levels and rising-edge pulses to the access-control
//                FSMs. Channels are filtered fully independently.
//  Revision    : 1.0 - initial release
// ============================================================================
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int CHANNELS        = 3,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] pulse_out,
  output logic                busy
);

  logic [CHANNELS-1:0] w_busy;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_raw   (raw_in[g]),
      .o_level (level_out[g]),
      .o_pulse (pulse_out[g]),
      .o_busy  (w_busy[g])
    );
  end : g_ch

  // A transition is pending on any channel whose counter is running
  assign busy = |w_busy;

endmodule : input_conditioner
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_input_conditioner
//  Description : Directed bench for input_conditioner (3 channels, debounce 4).
//                Every expected pulse event (cycle + vector) is queued when
//                its stimulus is applied. A monitor pops one entry per pulse
//                the DUT emits. Levels and busy are checked at fixed points.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_input_conditioner;
  import input_cond_pkg::*;

  localparam int LAT = DEBOUNCE_DEFAULT + 2;

  typedef struct {
    int         cyc;
    logic [2:0] vec;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] raw_in;
  logic [2:0] level_out;
  logic [2:0] pulse_out;
  logic       busy;

  int  cyc    = 0;
  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];

  input_conditioner #(
    .CHANNELS        (3),
    .DEBOUNCE_CYCLES (DEBOUNCE_DEFAULT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_in    (raw_in),
    .level_out (level_out),
    .pulse_out (pulse_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge n, cyc == n
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, req);
    end
  endtask

  task automatic expect_pulse(input int at, input logic [2:0] vec);
    ev_t e;
    e.cyc = at;
    e.vec = vec;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every pulse the DUT shows must match the next queued event
  always @(negedge clk) begin
    if (pulse_out !== 3'b000) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse at cycle %0d: got %b, expected none", cyc, pulse_out);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.vec !== pulse_out) begin
          errors++;
          $display("FAIL pulse_event: got %b at cycle %0d, expected %b at cycle %0d",
                   pulse_out, cyc, e.vec, e.cyc);
        end
      end
    end
  end

  initial begin
    int t;
    rst_n  = 1'b0;
    raw_in = 3'b111;

    // Reset held with all lines high: everything stays cleared
    tick(3);
    chk("reset_level", level_out, 3'b000);
    chk("reset_pulse", pulse_out, 3'b000);
    chk("reset_busy",  {2'b00, busy}, 3'b000);

    // Release with lines high -> fresh rise on every channel
    rst_n = 1'b1;
    expect_pulse(cyc + LAT, 3'b111);
    tick(LAT + 2);
    chk("release_level", level_out, 3'b111);
    chk("release_busy",  {2'b00, busy}, 3'b000);

    // Drop all lines: levels fall, no pulses
    raw_in = 3'b000;
    tick(LAT + 2);
    chk("fall_level", level_out, 3'b000);

    // Clean press on C1, busy window observed along the way
    raw_in[CH_C1] = 1'b1;
    t = cyc;
    expect_pulse(t + LAT, 3'b001);
    tick(2);
    chk("press_busy_c2", {2'b00, busy}, 3'b000);
    tick(1);
    chk("press_busy_c3", {2'b00, busy}, 3'b001);
    tick(2);
    chk("press_busy_c5", {2'b00, busy}, 3'b001);
    chk("press_level_c5", level_out, 3'b000);
    tick(1);
    chk("press_level_c6", level_out, 3'b001);
    chk("press_busy_c6", {2'b00, busy}, 3'b000);
    tick(2);

    // Bounce on C2: 1,0,1,0 then hold 1; only the final rise counts
    raw_in[CH_C2] = 1'b1; tick(1);
    raw_in[CH_C2] = 1'b0; tick(1);
    raw_in[CH_C2] = 1'b1; tick(1);
    raw_in[CH_C2] = 1'b0; tick(1);
    raw_in[CH_C2] = 1'b1;
    expect_pulse(cyc + LAT, 3'b010);
    tick(LAT - 1);
    chk("bounce_level_early", level_out, 3'b001);
    tick(3);
    chk("bounce_level", level_out, 3'b011);

    // Glitch on I: high for three cycles, then low -> rejected
    raw_in[CH_I] = 1'b1;
    tick(3);
    raw_in[CH_I] = 1'b0;
    tick(2);
    chk("glitch_busy_mid", {2'b00, busy}, 3'b001);
    tick(4);
    chk("glitch_level", level_out, 3'b011);
    chk("glitch_busy_end", {2'b00, busy}, 3'b000);

    // Bring C1/C2 low, then raise both together
    raw_in = 3'b000;
    tick(LAT + 2);
    chk("sim_pre_level", level_out, 3'b000);
    raw_in = 3'b011;
    expect_pulse(cyc + LAT, 3'b011);
    tick(LAT + 2);
    chk("sim_level", level_out, 3'b011);
    raw_in = 3'b000;
    tick(LAT + 2);
    chk("sim_release_level", level_out, 3'b000);

    // Mid-count reset: C1 rising, reset lands with cnt == 2
    raw_in = 3'b001;
    tick(4);
    chk("midrst_busy_before", {2'b00, busy}, 3'b001);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",  {2'b00, busy}, 3'b000);
    chk("midrst_level", level_out, 3'b000);
    chk("midrst_pulse", pulse_out, 3'b000);
    raw_in = 3'b000;
    tick(3);
    rst_n = 1'b1;
    tick(LAT + 4);
    chk("midrst_level_after", level_out, 3'b000);

    // Every queued pulse must have been consumed
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses: got %0d outstanding, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety bound on total run time
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_input_conditioner
`default_nettype wire
